in_channel_bank: RTL and testbench

Parametrised multi-channel input store for the zero VM FPGA harness. Holds `NChannels` independent FIFOs of `NIn` elements each. A host side streams values in through a valid/ready port. The VM executes `in` by popping one channel and `inSize` by querying that channel's remaining count. This replaces the fixed, preloaded single `inMem` array and allows the host to refill a channel while a program runs.

---
 rtl/in_channel_pkg.sv | 21 ++
 rtl/in_channel_fifo.sv | 80 ++++++++
 rtl/in_channel_bank.sv | 144 ++++++++++++++
 tb/tb_in_channel_bank.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/in_channel_pkg.sv
// -----------------------------------------------------------------------------
// in_channel_pkg
// Shared constants and helpers for the multi-channel input store.
//   DefMemoryElementWidth / DefNIn / DefNChannels : default build geometry
//   StatsWidth : width of the optional underflow statistics counter
//   idxNext()  : ring-index advance that wraps by compare-and-clear, so the
//                depth does not have to be a power of two
// -----------------------------------------------------------------------------
package in_channel_pkg;

    localparam int DefMemoryElementWidth = 12;
    localparam int DefNIn                = 8;
    localparam int DefNChannels          = 2;
    localparam int StatsWidth            = 8;

    function automatic int unsigned idxNext(input int unsigned idx,
                                            input int unsigned depth);
        return (idx == depth - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/in_channel_fifo.sv
// -----------------------------------------------------------------------------
// in_channel_fifo
// One channel of the input store: a ring buffer with head, tail and count.
// Ports:
//   clock, resetN      : clock, asynchronous active-low reset
//   push, push_data    : append push_data at the tail (ignored when full)
//   pop                : drop the head element (ignored when empty)
//   flush              : clear head, tail and count; wins over push and pop
//   count              : elements currently held (0..Depth)
//   empty, full        : count == 0 / count == Depth
//   head_data          : element at the head (valid when not empty)
// -----------------------------------------------------------------------------
module in_channel_fifo
    import in_channel_pkg::*;
#(
    parameter int Width      = DefMemoryElementWidth,
    parameter int Depth      = DefNIn,
    parameter int CountWidth = $clog2(Depth + 1)
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  push,
    input  logic [Width-1:0]      push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [CountWidth-1:0] count,
    output logic                  empty,
    output logic                  full,
    output logic [Width-1:0]      head_data
);

    localparam int IdxWidth = $clog2(Depth);

    logic [Width-1:0]      mem [Depth];
    logic [IdxWidth-1:0]   head;
    logic [IdxWidth-1:0]   tail;
    logic [CountWidth-1:0] count_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CountWidth'(Depth));
    assign count     = count_q;
    assign head_data = mem[head];

    assign do_push = push && !full  && !flush;
    assign do_pop  = pop  && !empty && !flush;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                tail <= IdxWidth'(idxNext(32'(tail), Depth));
            end
            if (do_pop) begin
                head <= IdxWidth'(idxNext(32'(head), Depth));
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CountWidth'(1);
                2'b01:   count_q <= count_q - CountWidth'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset: head/tail/count define which entries are live.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[tail] <= push_data;
        end
    end

endmodule

// File: rtl/in_channel_bank.sv
// -----------------------------------------------------------------------------
// in_channel_bank
// NChannels independent input FIFOs of NIn elements each. The host streams
// values in over a valid/ready port; the VM pops a channel with readReq and
// queries a channel's remaining count through sizeChannel/sizeCount.
// Optional feature macro: IN_CHANNEL_STATS_EN adds underflowCount, a
// saturating count of reads that hit an empty (or invalid/flushed) channel.
// Ports:
//   clock, resetN                      : clock, async active-low reset
//   loadValid, loadChannel, loadData   : host load offer
//   loadReady                          : comb; target in range, not full,
//                                        not being flushed
//   readReq, readChannel               : VM pop request
//   readData, readValid, readEmpty     : registered pop response
//   sizeChannel, sizeCount             : comb count of a channel
//   flush, flushChannel                : clear a channel
//   underflowCount (macro only)        : saturating empty-read counter
// -----------------------------------------------------------------------------
module in_channel_bank
    import in_channel_pkg::*;
#(
    parameter int MemoryElementWidth = DefMemoryElementWidth,
    parameter int NIn                = DefNIn,
    parameter int NChannels          = DefNChannels,
    parameter int ChanWidth          = (NChannels > 1) ? $clog2(NChannels) : 1,
    parameter int CountWidth         = $clog2(NIn + 1)
) (
    input  logic                          clock,
    input  logic                          resetN,
    input  logic                          loadValid,
    input  logic [ChanWidth-1:0]          loadChannel,
    input  logic [MemoryElementWidth-1:0] loadData,
    output logic                          loadReady,
    input  logic                          readReq,
    input  logic [ChanWidth-1:0]          readChannel,
    output logic [MemoryElementWidth-1:0] readData,
    output logic                          readValid,
    output logic                          readEmpty,
    input  logic [ChanWidth-1:0]          sizeChannel,
    output logic [CountWidth-1:0]         sizeCount,
    input  logic                          flush,
    input  logic [ChanWidth-1:0]          flushChannel
`ifdef IN_CHANNEL_STATS_EN
    ,
    output logic [StatsWidth-1:0]         underflowCount
`endif
);

    logic [NChannels-1:0]          push_v;
    logic [NChannels-1:0]          pop_v;
    logic [NChannels-1:0]          flush_v;
    logic [NChannels-1:0]          empty_v;
    logic [NChannels-1:0]          full_v;
    logic [CountWidth-1:0]         count_a [NChannels];
    logic [MemoryElementWidth-1:0] head_a  [NChannels];

    logic                          load_full;
    logic                          read_empty;
    logic [MemoryElementWidth-1:0] read_head;
    logic [CountWidth-1:0]         size_sel;
    logic                          load_flushed;
    logic                          read_flushed;
    logic                          load_fire;
    logic                          read_hit;

    // Channel selects. An index with no matching channel keeps the defaults,
    // which make it look full to loads, empty to reads and zero-sized.
    always_comb begin
        load_full  = 1'b1;
        read_empty = 1'b1;
        read_head  = '0;
        size_sel   = '0;
        for (int i = 0; i < NChannels; i++) begin
            if (loadChannel == ChanWidth'(i)) begin
                load_full = full_v[i];
            end
            if (readChannel == ChanWidth'(i)) begin
                read_empty = empty_v[i];
                read_head  = head_a[i];
            end
            if (sizeChannel == ChanWidth'(i)) begin
                size_sel = count_a[i];
            end
        end
    end

    assign load_flushed = flush && (flushChannel == loadChannel);
    assign read_flushed = flush && (flushChannel == readChannel);

    assign loadReady = resetN && !load_full && !load_flushed;
    assign load_fire = loadValid && loadReady;
    assign read_hit  = readReq && !read_empty && !read_flushed;
    assign sizeCount = size_sel;

    for (genvar g = 0; g < NChannels; g++) begin : g_chan
        assign push_v[g]  = load_fire && (loadChannel  == ChanWidth'(g));
        assign pop_v[g]   = read_hit  && (readChannel  == ChanWidth'(g));
        assign flush_v[g] = flush     && (flushChannel == ChanWidth'(g));

        in_channel_fifo #(
            .Width      (MemoryElementWidth),
            .Depth      (NIn),
            .CountWidth (CountWidth)
        ) u_fifo (
            .clock     (clock),
            .resetN    (resetN),
            .push      (push_v[g]),
            .push_data (loadData),
            .pop       (pop_v[g]),
            .flush     (flush_v[g]),
            .count     (count_a[g]),
            .empty     (empty_v[g]),
            .full      (full_v[g]),
            .head_data (head_a[g])
        );
    end

    // readData only moves on a successful pop, so an empty read leaves the
    // VM's target register unchanged.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            readData  <= '0;
            readValid <= 1'b0;
            readEmpty <= 1'b0;
        end else begin
            readValid <= read_hit;
            readEmpty <= readReq && !read_hit;
            if (read_hit) begin
                readData <= read_head;
            end
        end
    end

`ifdef IN_CHANNEL_STATS_EN
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            underflowCount <= '0;
        end else if (readReq && !read_hit && (underflowCount != '1)) begin
            underflowCount <= underflowCount + StatsWidth'(1);
        end
    end
`endif

endmodule

// File: tb/tb_in_channel_bank.sv
// -----------------------------------------------------------------------------
// tb_in_channel_bank
// Directed stimulus for in_channel_bank (NIn=3, NChannels=3). Each read pushes
// its hand-computed response into a queue; a negedge monitor pops and compares
// whenever readValid or readEmpty is presented.
// -----------------------------------------------------------------------------
module tb_in_channel_bank;

    localparam int W    = 12;
    localparam int NIN  = 3;
    localparam int NCH  = 3;
    localparam int CW   = 2;
    localparam int CNTW = 2;

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic          loadValid = 1'b0;
    logic [CW-1:0] loadChannel = '0;
    logic [W-1:0]  loadData = '0;
    logic          loadReady;
    logic          readReq = 1'b0;
    logic [CW-1:0] readChannel = '0;
    logic [W-1:0]  readData;
    logic          readValid;
    logic          readEmpty;
    logic [CW-1:0] sizeChannel = '0;
    logic [CNTW-1:0] sizeCount;
    logic          flush = 1'b0;
    logic [CW-1:0] flushChannel = '0;
`ifdef IN_CHANNEL_STATS_EN
    logic [7:0]    underflowCount;
`endif

    always #5 clock = ~clock;

    in_channel_bank #(
        .MemoryElementWidth (W),
        .NIn                (NIN),
        .NChannels          (NCH)
    ) dut (
`ifdef IN_CHANNEL_STATS_EN
        .underflowCount (underflowCount),
`endif
        .clock        (clock),
        .resetN       (resetN),
        .loadValid    (loadValid),
        .loadChannel  (loadChannel),
        .loadData     (loadData),
        .loadReady    (loadReady),
        .readReq      (readReq),
        .readChannel  (readChannel),
        .readData     (readData),
        .readValid    (readValid),
        .readEmpty    (readEmpty),
        .sizeChannel  (sizeChannel),
        .sizeCount    (sizeCount),
        .flush        (flush),
        .flushChannel (flushChannel)
    );

    typedef struct {
        bit           is_empty;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (resetN && (readValid || readEmpty)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_response: valid=%0b empty=%0b data=%0d, expected none",
                         readValid, readEmpty, readData);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("readValid", 32'(readValid), 32'(!e.is_empty));
                chk("readEmpty", 32'(readEmpty), 32'(e.is_empty));
                chk("readData",  32'(readData),  32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_read(input bit e, input int d);
        exp_t t;
        t.is_empty = e;
        t.data     = W'(d);
        sb.push_back(t);
    endtask

    task automatic load(input int ch, input int d, input bit rdy);
        loadValid   = 1'b1;
        loadChannel = CW'(ch);
        loadData    = W'(d);
        #1 chk("loadReady", 32'(loadReady), 32'(rdy));
        cyc();
        loadValid = 1'b0;
    endtask

    task automatic rd(input int ch, input bit e, input int d);
        readReq     = 1'b1;
        readChannel = CW'(ch);
        expect_read(e, d);
        cyc();
        readReq = 1'b0;
    endtask

    task automatic both(input int lch, input int ld, input bit rdy,
                        input int rch, input bit e, input int d);
        loadValid   = 1'b1;
        loadChannel = CW'(lch);
        loadData    = W'(ld);
        readReq     = 1'b1;
        readChannel = CW'(rch);
        #1 chk("loadReady_both", 32'(loadReady), 32'(rdy));
        expect_read(e, d);
        cyc();
        loadValid = 1'b0;
        readReq   = 1'b0;
    endtask

    task automatic size_is(input string nm, input int ch, input int exp);
        sizeChannel = CW'(ch);
        #1 chk(nm, 32'(sizeCount), 32'(exp));
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_readData",  32'(readData),  0);
        chk("rst_readValid", 32'(readValid), 0);
        chk("rst_readEmpty", 32'(readEmpty), 0);
        chk("rst_loadReady", 32'(loadReady), 0);
`ifdef IN_CHANNEL_STATS_EN
        chk("rst_underflow", 32'(underflowCount), 0);
`endif
        cyc();
        resetN = 1'b1;
        #1 chk("post_rst_loadReady", 32'(loadReady), 1);
        size_is("post_rst_size", 0, 0);

        // in-order load/read and empty read
        load(0, 88, 1);
        load(0, 44, 1);
        size_is("size_after_2_loads", 0, 2);
        rd(0, 0, 88);
        size_is("size_after_read1", 0, 1);
        rd(0, 0, 44);
        size_is("size_after_read2", 0, 0);
        rd(0, 1, 44);

        // full and wrap-around
        load(0, 1, 1);
        load(0, 2, 1);
        load(0, 3, 1);
        load(0, 99, 0);
        size_is("size_full", 0, 3);
        rd(0, 0, 1);
        rd(0, 0, 2);
        rd(0, 0, 3);
        load(0, 1, 1);
        load(0, 2, 1);
        for (int v = 3; v <= 10; v++) begin
            both(0, v, 1, 0, 0, v - 2);
            size_is("size_interleave", 0, 2);
        end
        rd(0, 0, 9);
        rd(0, 0, 10);
        size_is("size_drained", 0, 0);

        // simultaneous load and read on a full channel
        load(2, 5, 1);
        load(2, 6, 1);
        load(2, 7, 1);
        both(2, 8, 0, 2, 0, 5);
        size_is("size_full_both", 2, 2);
        rd(2, 0, 6);
        rd(2, 0, 7);

        // simultaneous load and read: partial and empty channel
        load(1, 20, 1);
        load(1, 21, 1);
        both(1, 7, 1, 1, 0, 20);
        size_is("size_mid_both", 1, 2);
        rd(1, 0, 21);
        rd(1, 0, 7);
        size_is("size_ch1_empty", 1, 0);
        both(1, 30, 1, 1, 1, 7);
        size_is("size_empty_both", 1, 1);
        rd(1, 0, 30);

        // out-of-range channel index
        load(3, 55, 0);
        size_is("size_oor", 3, 0);
        rd(3, 1, 30);

        // flush and channel isolation
        load(0, 1, 1);
        load(0, 2, 1);
        load(0, 3, 1);
        load(1, 4, 1);
        load(1, 5, 1);
        flush = 1'b1;
        flushChannel = 2'd0;
        load(0, 9, 0);
        flush = 1'b0;
        size_is("size_flushed_ch0", 0, 0);
        size_is("size_ch1_untouched", 1, 2);
        load(0, 11, 1);
        flush = 1'b1;
        rd(1, 0, 4);
        flush = 1'b0;
        size_is("size_ch0_flush2", 0, 0);
        size_is("size_ch1_after_read", 1, 1);
        load(0, 12, 1);
        flush = 1'b1;
        rd(0, 1, 4);
        flush = 1'b0;
        size_is("size_flush_read", 0, 0);

        // reset between two reads
        rd(1, 0, 5);
        load(2, 40, 1);
        cyc();
        resetN = 1'b0;
        loadChannel = 2'd0;
        #1;
        chk("midrst_readData",  32'(readData),  0);
        chk("midrst_readValid", 32'(readValid), 0);
        chk("midrst_readEmpty", 32'(readEmpty), 0);
        chk("midrst_loadReady", 32'(loadReady), 0);
        size_is("midrst_size2", 2, 0);
        cyc();
        resetN = 1'b1;
        size_is("postrst_size2", 2, 0);
        rd(2, 1, 0);

        // back-to-back empty reads (saturation of the stats counter)
        readReq = 1'b1;
        readChannel = 2'd0;
        for (int i = 0; i < 300; i++) begin
            expect_read(1, 0);
            cyc();
        end
        readReq = 1'b0;
        cyc();
        cyc();
`ifdef IN_CHANNEL_STATS_EN
        chk("underflow_saturated", 32'(underflowCount), 255);
`endif
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
